// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar slave responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package crossbar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        ACK     = 2'd2
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Wait counter width; supports 0..15 wait states.
    localparam int WAIT_CNT_W = 4;

    // Returned on out-of-range reads when range checking is compiled in.
    localparam logic [31:0] ERR_READ_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/slave_mem_array.sv
// Single-port synchronous RAM backing one slave port; contents are not reset.
// Latency: write commits on the clock edge; rdata is registered (one edge after index).
// Backpressure: none, one access per cycle.
//
// Ports: clk (rising edge), we (write enable), index (word index),
//        wdata (write data), rdata (registered read of mem[index]).
module slave_mem_array #(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] index,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // Read-before-write: a same-edge read returns the old word, which never
    // matters here because a transaction is either a read or a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/crossbar_slave_responder.sv
// Memory-backed target for one crossbar slave port, single-beat read/write.
// Latency: ack is a one-cycle pulse WAIT+1 cycles after the accepting edge; one transaction per WAIT+2 cycles.
// Backpressure: no req ready; requests are only accepted in IDLE, inputs are ignored until ack completes.
//
// Ports: clk, reset (async, active-high), req/cmd/addr from the crossbar,
//        rw (inout: write data in, read data out only during a read ack),
//        ack (completion pulse), err (only with SLV_RANGE_CHECK_EN:
//        out-of-range flag, valid with ack).
// Optional feature macro: SLV_RANGE_CHECK_EN.
module crossbar_slave_responder
    import crossbar_pkg::*;
#(
    parameter int M          = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         cmd,
    input  logic [M-1:0] addr,
    inout  wire  [M-1:0] rw,
    output logic         ack
`ifdef SLV_RANGE_CHECK_EN
    ,
    output logic         err
`endif
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    to_ack;
    logic [WAIT_CNT_W-1:0]   cnt;

    logic                    lat_cmd;
    logic [M-1:0]            lat_addr;
    logic [M-1:0]            lat_data;

    logic                    cur_cmd;
    logic [M-1:0]            cur_addr;
    logic [M-1:0]            cur_data;
    logic [DEPTH_LOG2-1:0]   index;
    logic                    we;
    logic [M-1:0]            rdata;
    logic                    rd_drive;
    logic [M-1:0]            rd_val;
    logic                    unused_addr_bits;

    wire accept = (state == IDLE) && req;

    // Next state. to_ack marks the edge that enters ACK; the memory access
    // happens on that edge so the data is ready in the ack cycle.
    always_comb begin
        state_nxt = state;
        to_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT > 0) begin
                        state_nxt = WAIT_ST;
                    end else begin
                        state_nxt = ACK;
                        to_ack    = 1'b1;
                    end
                end
            end
            WAIT_ST: begin
                if (cnt == WAIT_CNT_W'(1)) begin
                    state_nxt = ACK;
                    to_ack    = 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            lat_cmd  <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else if (accept) begin
            cnt      <= WAIT_CNT_W'(WAIT);
            lat_cmd  <= cmd;
            lat_addr <= addr;
            lat_data <= rw;
        end else if (state == WAIT_ST) begin
            cnt <= cnt - WAIT_CNT_W'(1);
        end
    end

    // With WAIT=0 the ACK-entry edge is the accepting edge, so the latches
    // are not loaded yet; take the live bus values while still in IDLE.
    assign cur_cmd  = (state == IDLE) ? cmd  : lat_cmd;
    assign cur_addr = (state == IDLE) ? addr : lat_addr;
    assign cur_data = (state == IDLE) ? rw   : lat_data;
    assign index    = cur_addr[DEPTH_LOG2+1:2];

`ifdef SLV_RANGE_CHECK_EN
    // Bit M-1 selects the slave port at the crossbar and is not part of the range.
    logic oor_cur;
    logic oor_lat;
    assign oor_cur = |cur_addr[M-2:DEPTH_LOG2+2];
    assign oor_lat = |lat_addr[M-2:DEPTH_LOG2+2];
    // reset gates the write so a request seen during reset never lands in memory.
    assign we     = to_ack && !reset && (cur_cmd == CMD_WRITE) && !oor_cur;
    assign rd_val = oor_lat ? M'(ERR_READ_DATA) : rdata;
    assign err    = (state == ACK) && oor_lat;
    assign unused_addr_bits = ^{cur_addr[M-1], cur_addr[1:0]};
`else
    assign we     = to_ack && !reset && (cur_cmd == CMD_WRITE);
    assign rd_val = rdata;
    assign unused_addr_bits = ^{cur_addr[M-1:DEPTH_LOG2+2], cur_addr[1:0]};
`endif

    slave_mem_array #(
        .W  (M),
        .AW (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .index (index),
        .wdata (cur_data),
        .rdata (rdata)
    );

    assign ack = (state == ACK);

    // Only drive the shared bus while returning read data; any other time the
    // crossbar's write-direction drivers own it.
    assign rd_drive = (state == ACK) && (lat_cmd == CMD_READ);
    assign rw       = rd_drive ? rd_val : {M{1'bz}};

endmodule

// File: tb/tb_crossbar_slave_responder.sv
// Directed bench for crossbar_slave_responder: two instances (WAIT=2 and WAIT=0)
// share the cmd/addr/rw bus, each with its own req. Expected responses are queued
// when a request is issued and compared when ack is observed.
module tb_crossbar_slave_responder;

    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;
    localparam logic [31:0] PROBE = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, cmd;
    logic [31:0] addr;
    logic [31:0] tb_rw;
    logic        tb_drv;
    wire  [31:0] rw;
    logic        ack_a, ack_b;
`ifdef SLV_RANGE_CHECK_EN
    logic        err_a, err_b;
`endif

    // The bench keeps a known pattern on rw whenever it is not expecting read
    // data; a responder driving the bus at the wrong time disturbs it.
    assign rw = tb_drv ? tb_rw : 32'bz;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    crossbar_slave_responder #(.M(32), .DEPTH_LOG2(8), .WAIT(WAIT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .req   (req_a),
        .cmd   (cmd),
        .addr  (addr),
        .rw    (rw),
        .ack   (ack_a)
`ifdef SLV_RANGE_CHECK_EN
        ,
        .err   (err_a)
`endif
    );

    crossbar_slave_responder #(.M(32), .DEPTH_LOG2(8), .WAIT(WAIT_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .req   (req_b),
        .cmd   (cmd),
        .addr  (addr),
        .rw    (rw),
        .ack   (ack_b)
`ifdef SLV_RANGE_CHECK_EN
        ,
        .err   (err_b)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        is_read;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on dut_a (sel=0) or dut_b (sel=1). disturb changes
    // addr/rw right after the accepting edge to show the latched values win.
    task automatic txn(input bit sel, input logic c, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d,
                       input logic exp_e, input bit disturb);
        exp_t e;
        bit   seen;
        e.data    = exp_d;
        e.is_read = (c == 1'b0);
        e.err     = exp_e;
        e.lat     = sel ? WAIT_B + 1 : WAIT_A + 1;
        sb.push_back(e);
        @(negedge clk);
        cmd = c; addr = a; tb_rw = d; tb_drv = 1'b1;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        if (c == 1'b0) tb_drv = 1'b0; else tb_rw = PROBE;
        if (disturb) begin
            addr = a + 32'd4; tb_rw = 32'h0000_FFFF; tb_drv = 1'b1;
        end
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (sel ? ack_b : ack_a) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("ack_latency", n, e.lat);
                if (e.is_read) chk("read_data", rw, e.data);
                else           chk("write_ack_rw_released", rw, tb_rw);
`ifdef SLV_RANGE_CHECK_EN
                chk("err_with_ack", sel ? err_b : err_a, e.err);
`endif
            end else if (tb_drv) begin
                chk("rw_released_wait", rw, tb_rw);
            end
        end
        chk("ack_seen", {31'b0, seen}, 32'd1);
        if (!seen && sb.size() > 0) e = sb.pop_front();
        @(posedge clk); #1;
        tb_drv = 1'b1; tb_rw = PROBE; addr = 32'h0;
        @(negedge clk);
        chk("ack_one_cycle", sel ? ack_b : ack_a, 32'd0);
        chk("rw_released_idle", rw, tb_rw);
    endtask

    initial begin
        exp_t e;
        int   c0;
        int   got;

        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; cmd = 1'b0; addr = 32'h0;
        tb_rw = PROBE; tb_drv = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ack_a", ack_a, 32'd0);
        chk("reset_ack_b", ack_b, 32'd0);
        chk("reset_rw", rw, PROBE);
        reset = 1'b0;

        // Write then read back, WAIT=2; also bit 31 (port select) is ignored.
        txn(0, 1'b1, 32'h10, 32'hA5A5_0001, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 32'hA5A5_0001, 1'b0, 0);
        txn(0, 1'b0, 32'h8000_0010, 32'h0, 32'hA5A5_0001, 1'b0, 0);

        // Back-to-back reads on the WAIT=0 instance after preloading 1..4.
        for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(4 * i), 32'(i + 1), 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            e.data = 32'(i + 1); e.is_read = 1'b1; e.err = 1'b0; e.lat = 2 * i + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        cmd = 1'b0; addr = 32'h0; tb_drv = 1'b0; req_b = 1'b1; c0 = cyc;
        got = 0;
        for (int n = 0; n < 30 && got < 4; n++) begin
            @(negedge clk);
            if (ack_b) begin
                e = sb.pop_front();
                chk("b2b_ack_cycle", cyc - c0, e.lat);
                chk("b2b_data", rw, e.data);
                got++;
                addr = 32'(4 * got);
                if (got == 4) req_b = 1'b0;
            end
        end
        chk("b2b_count", got, 32'd4);
        req_b = 1'b0;
        @(posedge clk); #1;
        tb_drv = 1'b1; tb_rw = PROBE;

        // Bus changes during WAIT_ST are ignored.
        txn(0, 1'b1, 32'h24, 32'h0000_CAFE, 32'h0, 1'b0, 0);
        txn(0, 1'b1, 32'h20, 32'h0000_1234, 32'h0, 1'b0, 1);
        txn(0, 1'b0, 32'h20, 32'h0, 32'h0000_1234, 1'b0, 0);
        txn(0, 1'b0, 32'h24, 32'h0, 32'h0000_CAFE, 1'b0, 0);

        // Reset during WAIT_ST discards the pending write.
        txn(0, 1'b1, 32'h30, 32'h11, 32'h0, 1'b0, 0);
        @(negedge clk);
        cmd = 1'b1; addr = 32'h30; tb_rw = 32'h55; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; tb_rw = PROBE;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ack", ack_a, 32'd0);
        chk("midrst_rw", rw, PROBE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_ack_held", ack_a, 32'd0);
        end
        reset = 1'b0;
        txn(0, 1'b0, 32'h30, 32'h0, 32'h11, 1'b0, 0);

        // Upper address bits: wrap by default, flagged with range checking.
        txn(0, 1'b1, 32'h0, 32'h33, 32'h0, 1'b0, 0);
`ifdef SLV_RANGE_CHECK_EN
        txn(0, 1'b1, 32'h400, 32'h99, 32'h0, 1'b1, 0);
        txn(0, 1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 32'h33, 1'b0, 0);
`else
        txn(0, 1'b1, 32'h400, 32'h77, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 32'h77, 1'b0, 0);
        txn(0, 1'b0, 32'h7F0_0400, 32'h0, 32'h77, 1'b0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
